// File: rtl/sdp_ram_32x1024.sv
// Simple dual-port synchronous RAM: one write port and one registered read port, single clock.
// Define OUTPUT_REG_EN to add a second output register (read latency 2 instead of 1).
module sdp_ram_32x1024 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Storage is never reset, so writes still land while rst_n is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of mem gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

`ifdef OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign rd_data = out_q;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_sdp_ram_32x1024.sv
// Self-checking bench for sdp_ram_32x1024; a reference model feeds a scoreboard of expected rd_data.
// Compile with OUTPUT_REG_EN defined to check the two-stage read pipeline.
module tb_sdp_ram_32x1024;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 2 ** AW;
`ifdef OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] val;
    bit            known;
    string         tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] model [DEPTH];
  bit            written [DEPTH];
  exp_t          stage1;
  exp_t          sb [$];
  int            errors = 0;
  int            checks = 0;

  sdp_ram_32x1024 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // One clock: drive on negedge, predict, then compare #1 after the rising edge.
  task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra, input string tag);
    exp_t s1, e;
    @(negedge clk);
    rst_n   = ~rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    if (rst) begin
      s1.val = '0; s1.known = 1'b1;
    end else begin
      s1.val = model[ra]; s1.known = written[ra];
    end
    s1.tag = tag;
    if (LAT == 1) begin
      e = s1;
    end else if (rst) begin
      e.val = '0; e.known = 1'b1; e.tag = tag;
    end else begin
      e = stage1;
      e.tag = tag;
    end
    stage1 = s1;
    sb.push_back(e);
    if (we) begin
      model[wa]   = wd;
      written[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.known) begin
      checks++;
      if (rd_data !== e.val) begin
        errors++;
        $display("FAIL %s: rd_data=%h expected=%h (t=%0t)", e.tag, rd_data, e.val, $time);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, AW'(100 + i), DW'(32'hC0DE_0000 + i), '0, "reset_hold");
    end
    cycle(1'b0, 1'b0, '0, '0, '0, "reset_release");
    cycle(1'b0, 1'b0, '0, '0, '0, "reset_release2");
    for (int i = 0; i < 20 + LAT; i++) begin
      cycle(1'b0, 1'b0, '0, '0, AW'(100 + (i % 20)), "write_during_reset");
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, AW'(i), 32'hFFFF_FFFF - DW'(i), '0, "fill_write");
    end
    for (int i = 0; i < DEPTH + LAT; i++) begin
      cycle(1'b0, 1'b0, '0, '0, AW'(i % DEPTH), "fill_read");
    end
  endtask

  task automatic test_boundary;
    cycle(1'b0, 1'b1, '0, 32'h1234_5678, '0, "bnd_write0");
    cycle(1'b0, 1'b1, '1, 32'hDEAD_BEEF, '0, "bnd_write_top");
    cycle(1'b0, 1'b0, '0, '0, '1, "bnd_read_top");
    cycle(1'b0, 1'b0, '0, '0, '0, "bnd_read0");
    for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0, '0, "bnd_drain");
  endtask

  task automatic test_read_during_write;
    cycle(1'b0, 1'b1, AW'(5), 32'hAAAA_5555, AW'(6), "rdw_setup");
    cycle(1'b0, 1'b1, AW'(5), 32'h0F0F_0F0F, AW'(5), "rdw_same_addr");
    cycle(1'b0, 1'b0, '0, '0, AW'(5), "rdw_next");
    for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0, AW'(5), "rdw_drain");
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 12; i++) begin
      cycle(i == 5, i == 5, AW'(300), 32'h5A5A_0001, AW'(200 + i), "mid_reset");
    end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] wa, ra;
    for (int i = 0; i < 200; i++) begin
      wa = AW'($urandom_range(0, 15));
      ra = AW'($urandom_range(0, 15));
      cycle(1'b0, 1'($urandom_range(0, 1)), wa, DW'($urandom), ra, "b2b_random");
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    stage1.val = '0; stage1.known = 1'b0; stage1.tag = "";
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    test_reset();
    test_fill();
    test_boundary();
    test_read_during_write();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
